// File: rtl/axi_arbiter.sv
// Two-requester (IFU/LSU) arbiter onto one AXI4 master port, one single-beat transaction at a time.
// Define AXI_ARB_RR_EN for round-robin arbitration; default is fixed priority, LSU over IFU.
module axi_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  // IFU
  input  logic                  ifu_req_valid,
  output logic                  ifu_req_ready,
  input  logic [ADDR_W-1:0]     ifu_addr,
  output logic                  ifu_resp_valid,
  output logic [DATA_W-1:0]     ifu_resp_data,
  output logic                  ifu_resp_err,
  // LSU
  input  logic                  lsu_req_valid,
  output logic                  lsu_req_ready,
  input  logic                  lsu_wen,
  input  logic [ADDR_W-1:0]     lsu_addr,
  input  logic [2:0]            lsu_size,
  input  logic [DATA_W-1:0]     lsu_wdata,
  input  logic [DATA_W/8-1:0]   lsu_wstrb,
  output logic                  lsu_resp_valid,
  output logic [DATA_W-1:0]     lsu_resp_rdata,
  output logic                  lsu_resp_err,
  // AXI AR
  output logic                  io_master_arvalid,
  input  logic                  io_master_arready,
  output logic [ADDR_W-1:0]     io_master_araddr,
  output logic [3:0]            io_master_arid,
  output logic [7:0]            io_master_arlen,
  output logic [2:0]            io_master_arsize,
  output logic [1:0]            io_master_arburst,
  // AXI R
  input  logic                  io_master_rvalid,
  output logic                  io_master_rready,
  input  logic [1:0]            io_master_rresp,
  input  logic [DATA_W-1:0]     io_master_rdata,
  input  logic                  io_master_rlast,
  input  logic [3:0]            io_master_rid,
  // AXI AW
  output logic                  io_master_awvalid,
  input  logic                  io_master_awready,
  output logic [ADDR_W-1:0]     io_master_awaddr,
  output logic [3:0]            io_master_awid,
  output logic [7:0]            io_master_awlen,
  output logic [2:0]            io_master_awsize,
  output logic [1:0]            io_master_awburst,
  // AXI W
  output logic                  io_master_wvalid,
  input  logic                  io_master_wready,
  output logic [DATA_W-1:0]     io_master_wdata,
  output logic [DATA_W/8-1:0]   io_master_wstrb,
  output logic                  io_master_wlast,
  // AXI B
  input  logic                  io_master_bvalid,
  output logic                  io_master_bready,
  input  logic [1:0]            io_master_bresp,
  input  logic [3:0]            io_master_bid
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [2:0] {StIdle, StRdAr, StRdR, StWrAww, StWrB} state_e;

  state_e              state_q, state_d;
  logic                owner_q, owner_d;  // 1 = LSU
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [2:0]          size_q, size_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic                ifu_rv_q, ifu_rv_d, ifu_err_q, ifu_err_d;
  logic                lsu_rv_q, lsu_rv_d, lsu_err_q, lsu_err_d;
  logic [DATA_W-1:0]   ifu_rdata_q, ifu_rdata_d, lsu_rdata_q, lsu_rdata_d;
  logic                idle, grant_lsu, aw_hs, w_hs;

  logic unused_inputs;
  assign unused_inputs = ^{io_master_rid, io_master_bid, io_master_rresp[0], io_master_bresp[0]};

`ifdef AXI_ARB_RR_EN
  logic rr_ptr_q, rr_ptr_d;  // 0 = LSU preferred
  assign grant_lsu = lsu_req_valid & (~ifu_req_valid | ~rr_ptr_q);
`else
  assign grant_lsu = lsu_req_valid;
`endif

  // Readies are gated by reset so nothing can be accepted while it is held.
  assign idle          = (state_q == StIdle) & reset;
  assign lsu_req_ready = idle & grant_lsu;
  assign ifu_req_ready = idle & ifu_req_valid & ~grant_lsu;

  assign aw_hs = io_master_awvalid & io_master_awready;
  assign w_hs  = io_master_wvalid & io_master_wready;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    addr_d      = addr_q;
    size_d      = size_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    aw_done_d   = aw_done_q;
    w_done_d    = w_done_q;
    ifu_rv_d    = 1'b0;
    ifu_err_d   = ifu_err_q;
    ifu_rdata_d = ifu_rdata_q;
    lsu_rv_d    = 1'b0;
    lsu_err_d   = lsu_err_q;
    lsu_rdata_d = lsu_rdata_q;
`ifdef AXI_ARB_RR_EN
    rr_ptr_d    = rr_ptr_q;
`endif
    case (state_q)
      StIdle: begin
        if (lsu_req_ready) begin
          owner_d = 1'b1;
          addr_d  = lsu_addr;
          size_d  = lsu_size;
          wdata_d = lsu_wdata;
          wstrb_d = lsu_wstrb;
          state_d = lsu_wen ? StWrAww : StRdAr;
`ifdef AXI_ARB_RR_EN
          rr_ptr_d = 1'b1;
`endif
        end else if (ifu_req_ready) begin
          owner_d = 1'b0;
          addr_d  = ifu_addr;
          size_d  = 3'd2;
          state_d = StRdAr;
`ifdef AXI_ARB_RR_EN
          rr_ptr_d = 1'b0;
`endif
        end
      end
      StRdAr: if (io_master_arready) state_d = StRdR;
      StRdR: begin
        if (io_master_rvalid) begin
          // A single beat without RLAST is a protocol error.
          if (owner_q) begin
            lsu_rv_d    = 1'b1;
            lsu_rdata_d = io_master_rdata;
            lsu_err_d   = io_master_rresp[1] | ~io_master_rlast;
          end else begin
            ifu_rv_d    = 1'b1;
            ifu_rdata_d = io_master_rdata;
            ifu_err_d   = io_master_rresp[1] | ~io_master_rlast;
          end
          state_d = StIdle;
        end
      end
      StWrAww: begin
        aw_done_d = aw_done_q | aw_hs;
        w_done_d  = w_done_q | w_hs;
        if ((aw_done_q | aw_hs) & (w_done_q | w_hs)) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = StWrB;
        end
      end
      StWrB: begin
        if (io_master_bvalid) begin
          lsu_rv_d  = 1'b1;
          lsu_err_d = io_master_bresp[1];
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      owner_q     <= 1'b0;
      addr_q      <= '0;
      size_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      ifu_rv_q    <= 1'b0;
      ifu_err_q   <= 1'b0;
      ifu_rdata_q <= '0;
      lsu_rv_q    <= 1'b0;
      lsu_err_q   <= 1'b0;
      lsu_rdata_q <= '0;
`ifdef AXI_ARB_RR_EN
      rr_ptr_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      ifu_rv_q    <= ifu_rv_d;
      ifu_err_q   <= ifu_err_d;
      ifu_rdata_q <= ifu_rdata_d;
      lsu_rv_q    <= lsu_rv_d;
      lsu_err_q   <= lsu_err_d;
      lsu_rdata_q <= lsu_rdata_d;
`ifdef AXI_ARB_RR_EN
      rr_ptr_q    <= rr_ptr_d;
`endif
    end
  end

  assign ifu_resp_valid = ifu_rv_q;
  assign ifu_resp_data  = ifu_rdata_q;
  assign ifu_resp_err   = ifu_err_q;
  assign lsu_resp_valid = lsu_rv_q;
  assign lsu_resp_rdata = lsu_rdata_q;
  assign lsu_resp_err   = lsu_err_q;

  assign io_master_arvalid = (state_q == StRdAr);
  assign io_master_araddr  = addr_q;
  assign io_master_arid    = {3'b000, owner_q};
  assign io_master_arlen   = 8'd0;
  assign io_master_arsize  = size_q;
  assign io_master_arburst = 2'b01;
  assign io_master_rready  = (state_q == StRdR);

  assign io_master_awvalid = (state_q == StWrAww) & ~aw_done_q;
  assign io_master_awaddr  = addr_q;
  assign io_master_awid    = 4'd1;
  assign io_master_awlen   = 8'd0;
  assign io_master_awsize  = size_q;
  assign io_master_awburst = 2'b01;
  assign io_master_wvalid  = (state_q == StWrAww) & ~w_done_q;
  assign io_master_wdata   = wdata_q;
  assign io_master_wstrb   = wstrb_q;
  assign io_master_wlast   = 1'b1;
  assign io_master_bready  = (state_q == StWrB);

endmodule

// File: tb/tb_axi_arbiter.sv
// Directed testbench for axi_arbiter: fetch, store, arbitration, stalled load, mid-transaction reset.
module tb_axi_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;

  logic clock, reset;
  logic ifu_req_valid, ifu_req_ready, ifu_resp_valid, ifu_resp_err;
  logic [ADDR_W-1:0] ifu_addr;
  logic [DATA_W-1:0] ifu_resp_data;
  logic lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid, lsu_resp_err;
  logic [ADDR_W-1:0] lsu_addr;
  logic [2:0] lsu_size;
  logic [DATA_W-1:0] lsu_wdata, lsu_resp_rdata;
  logic [STRB_W-1:0] lsu_wstrb;
  logic arvalid, arready, rvalid, rready, rlast, awvalid, awready, wvalid, wready, wlast;
  logic bvalid, bready;
  logic [ADDR_W-1:0] araddr, awaddr;
  logic [3:0] arid, rid, awid, bid;
  logic [7:0] arlen, awlen;
  logic [2:0] arsize, awsize;
  logic [1:0] arburst, awburst, rresp, bresp;
  logic [DATA_W-1:0] rdata, wdata;
  logic [STRB_W-1:0] wstrb;

  int n_checks = 0;
  int n_fail = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  axi_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clock(clock), .reset(reset),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_data(ifu_resp_data), .ifu_resp_err(ifu_resp_err),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_wen(lsu_wen),
    .lsu_addr(lsu_addr), .lsu_size(lsu_size), .lsu_wdata(lsu_wdata), .lsu_wstrb(lsu_wstrb),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_rdata(lsu_resp_rdata),
    .lsu_resp_err(lsu_resp_err),
    .io_master_arvalid(arvalid), .io_master_arready(arready), .io_master_araddr(araddr),
    .io_master_arid(arid), .io_master_arlen(arlen), .io_master_arsize(arsize),
    .io_master_arburst(arburst),
    .io_master_rvalid(rvalid), .io_master_rready(rready), .io_master_rresp(rresp),
    .io_master_rdata(rdata), .io_master_rlast(rlast), .io_master_rid(rid),
    .io_master_awvalid(awvalid), .io_master_awready(awready), .io_master_awaddr(awaddr),
    .io_master_awid(awid), .io_master_awlen(awlen), .io_master_awsize(awsize),
    .io_master_awburst(awburst),
    .io_master_wvalid(wvalid), .io_master_wready(wready), .io_master_wdata(wdata),
    .io_master_wstrb(wstrb), .io_master_wlast(wlast),
    .io_master_bvalid(bvalid), .io_master_bready(bready), .io_master_bresp(bresp),
    .io_master_bid(bid)
  );

  task automatic do_reset();
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_reset();
    logic [8:0] ctrl;
    reset = 1'b0; ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    repeat (2) @(negedge clock);
    ctrl = {ifu_req_ready, lsu_req_ready, arvalid, awvalid, wvalid, rready, bready,
            ifu_resp_valid, lsu_resp_valid};
    n_checks++;
    if (ctrl !== 9'b0) begin
      n_fail++; $display("FAIL reset_ctrl: got %b want 000000000", ctrl);
    end
    n_checks++;
    if ({ifu_resp_data, lsu_resp_rdata, ifu_resp_err, lsu_resp_err} !== '0) begin
      n_fail++; $display("FAIL reset_data: got %h/%h want 0", ifu_resp_data, lsu_resp_rdata);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic ifu_fetch(input logic [31:0] addr, input logic [31:0] data,
                           input logic last, input logic exp_err);
    ifu_req_valid = 1'b1; ifu_addr = addr;
    #1;
    n_checks++;
    if (ifu_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL fetch_ready: got %b want 1", ifu_req_ready);
    end
    @(negedge clock);
    ifu_req_valid = 1'b0;
    n_checks++;
    if ({arvalid, araddr, arid, arsize, arlen, arburst} !== {1'b1, addr, 4'd0, 3'd2, 8'd0, 2'b01})
    begin
      n_fail++;
      $display("FAIL fetch_ar: got v=%b a=%h id=%0d sz=%0d want v=1 a=%h id=0 sz=2",
               arvalid, araddr, arid, arsize, addr);
    end
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    n_checks++;
    if ({rready, ifu_resp_valid} !== 2'b10) begin
      n_fail++; $display("FAIL fetch_rready: got %b want 10", {rready, ifu_resp_valid});
    end
    rvalid = 1'b1; rdata = data; rlast = last; rresp = 2'b00;
    @(negedge clock);
    rvalid = 1'b0; rlast = 1'b1;
    n_checks++;
    if ({ifu_resp_valid, ifu_resp_data, ifu_resp_err} !== {1'b1, data, exp_err}) begin
      n_fail++;
      $display("FAIL fetch_resp: got v=%b d=%h e=%b want v=1 d=%h e=%b",
               ifu_resp_valid, ifu_resp_data, ifu_resp_err, data, exp_err);
    end
    @(negedge clock);
    n_checks++;
    if ({ifu_resp_valid, ifu_resp_data} !== {1'b0, data}) begin
      n_fail++;
      $display("FAIL fetch_hold: got v=%b d=%h want v=0 d=%h", ifu_resp_valid, ifu_resp_data, data);
    end
  endtask

  task automatic test_ifu_fetch();
    ifu_fetch(32'h8000_0000, 32'h0000_0413, 1'b1, 1'b0);
  endtask

  task automatic test_store();
    int aw_cnt = 0, w_cnt = 0, resp_cnt = 0;
    logic resp_err = 1'b0;
    logic b_done = 1'b0;
    lsu_req_valid = 1'b1; lsu_wen = 1'b1; lsu_addr = 32'h8000_0100; lsu_size = 3'd2;
    lsu_wdata = 32'hDEAD_BEEF; lsu_wstrb = 4'b1111;
    #1;
    n_checks++;
    if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
      n_fail++; $display("FAIL store_ready: got %b want 10", {lsu_req_ready, ifu_req_ready});
    end
    @(negedge clock);
    lsu_req_valid = 1'b0; lsu_wdata = '0; lsu_addr = '0;
    bresp = 2'b10;
    for (int cyc = 0; cyc < 10; cyc++) begin
      if (lsu_resp_valid) begin resp_cnt++; resp_err = lsu_resp_err; end
      wready = (cyc == 0); awready = (cyc == 2); bvalid = (cyc >= 3) && !b_done;
      #1;
      if (cyc == 1) begin
        n_checks++;
        if ({awvalid, wvalid} !== 2'b10) begin
          n_fail++; $display("FAIL store_hold: got aw/w=%b want 10", {awvalid, wvalid});
        end
      end
      if (awvalid && awready) begin
        aw_cnt++;
        n_checks++;
        if ({awaddr, awid, awsize, awlen} !== {32'h8000_0100, 4'd1, 3'd2, 8'd0}) begin
          n_fail++; $display("FAIL store_aw: got a=%h id=%0d sz=%0d", awaddr, awid, awsize);
        end
      end
      if (wvalid && wready) begin
        w_cnt++;
        n_checks++;
        if ({wdata, wstrb, wlast} !== {32'hDEAD_BEEF, 4'b1111, 1'b1}) begin
          n_fail++; $display("FAIL store_w: got d=%h s=%b l=%b", wdata, wstrb, wlast);
        end
      end
      if (bvalid && bready) b_done = 1'b1;
      @(negedge clock);
    end
    wready = 1'b0; awready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
    n_checks++;
    if ({aw_cnt, w_cnt, resp_cnt} !== {32'd1, 32'd1, 32'd1}) begin
      n_fail++; $display("FAIL store_counts: got aw=%0d w=%0d resp=%0d want 1 1 1",
                         aw_cnt, w_cnt, resp_cnt);
    end
    n_checks++;
    if (resp_err !== 1'b1) begin
      n_fail++; $display("FAIL store_err: got %b want 1", resp_err);
    end
  endtask

  task automatic test_arbitration();
    logic [3:0] order = '0;
    logic [3:0] exp_order;
    int g = 0;
`ifdef AXI_ARB_RR_EN
    exp_order = 4'b0101;  // bit i = 1 when grant i went to LSU
`else
    exp_order = 4'b1111;
`endif
    do_reset();
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0010;
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0200; lsu_size = 3'd2;
    arready = 1'b1; rvalid = 1'b1; rlast = 1'b1; rresp = 2'b00; rdata = 32'h1111_2222;
    for (int cyc = 0; cyc < 40 && g < 4; cyc++) begin
      #1;
      if (ifu_req_ready || lsu_req_ready) begin
        n_checks++;
        if (ifu_req_ready && lsu_req_ready) begin
          n_fail++; $display("FAIL arb_exclusive: got both ready want one");
        end
        order[g] = lsu_req_ready;
        g++;
      end
      @(negedge clock);
    end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    repeat (4) @(negedge clock);
    arready = 1'b0; rvalid = 1'b0;
    n_checks++;
    if (g !== 4) begin
      n_fail++; $display("FAIL arb_count: got %0d grants want 4", g);
    end
    n_checks++;
    if (order !== exp_order) begin
      n_fail++; $display("FAIL arb_order: got %b want %b", order, exp_order);
    end
  endtask

  task automatic test_lsu_byte_load();
    int resp_cnt = 0;
    logic [31:0] got = '0;
    lsu_req_valid = 1'b1; lsu_wen = 1'b0; lsu_addr = 32'h8000_0003; lsu_size = 3'd0;
    #1;
    n_checks++;
    if (lsu_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL load_ready: got %b want 1", lsu_req_ready);
    end
    @(negedge clock);
    lsu_req_valid = 1'b0; lsu_addr = '0; lsu_size = 3'd2;
    rdata = 32'h0000_00AB; rlast = 1'b1; rresp = 2'b00;
    for (int cyc = 0; cyc < 15; cyc++) begin
      if (lsu_resp_valid) begin resp_cnt++; got = lsu_resp_rdata; end
      arready = (cyc == 5); rvalid = (cyc == 9);
      #1;
      if (cyc <= 5) begin
        n_checks++;
        if ({arvalid, araddr, arid, arsize} !== {1'b1, 32'h8000_0003, 4'd1, 3'd0}) begin
          n_fail++; $display("FAIL load_ar_c%0d: got v=%b a=%h id=%0d sz=%0d want 1 80000003 1 0",
                             cyc, arvalid, araddr, arid, arsize);
        end
      end
      if (cyc == 9) begin
        n_checks++;
        if (rready !== 1'b1) begin
          n_fail++; $display("FAIL load_rready: got %b want 1", rready);
        end
      end
      @(negedge clock);
    end
    arready = 1'b0; rvalid = 1'b0;
    n_checks++;
    if ({resp_cnt, got} !== {32'd1, 32'h0000_00AB}) begin
      n_fail++; $display("FAIL load_resp: got cnt=%0d d=%h want 1 000000ab", resp_cnt, got);
    end
  endtask

  task automatic test_reset_mid();
    int pulses = 0;
    ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0040;
    @(negedge clock);
    ifu_req_valid = 1'b0; arready = 1'b1;
    @(negedge clock);
    arready = 1'b0;
    n_checks++;
    if (rready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_inrdr: got rready=%b want 1", rready);
    end
    reset = 1'b0; ifu_req_valid = 1'b1; ifu_addr = 32'h8000_0080;
    #1;
    n_checks++;
    if ({ifu_req_ready, lsu_req_ready, arvalid, rready, awvalid, wvalid, bready,
         ifu_resp_valid, lsu_resp_valid} !== 9'b0) begin
      n_fail++; $display("FAIL rst_mid_ctrl: got rr=%b ifu_rdy=%b want 0", rready, ifu_req_ready);
    end
    n_checks++;
    if ({ifu_resp_data, lsu_resp_rdata, ifu_resp_err, lsu_resp_err} !== '0) begin
      n_fail++; $display("FAIL rst_mid_data: got %h/%h want 0", ifu_resp_data, lsu_resp_rdata);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (ifu_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_accept: got %b want 1", ifu_req_ready);
    end
    @(negedge clock);
    ifu_req_valid = 1'b0;
    n_checks++;
    if ({arvalid, araddr, ifu_resp_valid, lsu_resp_valid} !== {1'b1, 32'h8000_0080, 2'b00}) begin
      n_fail++; $display("FAIL rst_mid_ar: got v=%b a=%h pulses=%b%b want 1 80000080 00",
                         arvalid, araddr, ifu_resp_valid, lsu_resp_valid);
    end
    arready = 1'b1;
    @(negedge clock);
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h5555_AAAA; rlast = 1'b1; rresp = 2'b00;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clock);
      rvalid = 1'b0;
      if (ifu_resp_valid || lsu_resp_valid) pulses++;
    end
    n_checks++;
    if ({pulses, ifu_resp_data} !== {32'd1, 32'h5555_AAAA}) begin
      n_fail++; $display("FAIL rst_mid_resp: got pulses=%0d d=%h want 1 5555aaaa",
                         pulses, ifu_resp_data);
    end
  endtask

  task automatic test_rlast_err();
    ifu_fetch(32'h8000_0004, 32'h1234_5678, 1'b0, 1'b1);
  endtask

  initial begin
    reset = 1'b0;
    ifu_req_valid = 1'b0; ifu_addr = '0;
    lsu_req_valid = 1'b0; lsu_wen = 1'b0; lsu_addr = '0; lsu_size = '0;
    lsu_wdata = '0; lsu_wstrb = '0;
    arready = 1'b0; rvalid = 1'b0; rresp = '0; rdata = '0; rlast = 1'b1; rid = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = '0; bid = '0;
    test_reset();
    test_ifu_fetch();
    test_store();
    test_arbitration();
    test_lsu_byte_load();
    test_reset_mid();
    test_rlast_err();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish within 100000 time units");
    $fatal(1);
  end

endmodule
